// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered, back-pressurable result/flag/tag output.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 1001).
module alu_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       ALU_control,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow,
   output logic             illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_SRA  = 4'b1101;

   logic [WIDTH:0]   add_w, sub_w;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_o, alu_ill;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d, ill_q, ill_d;
   logic [TAG_W-1:0] tag_q, tag_d;

   logic in_xfer, out_xfer, reg_free, is_mul;

   assign shamt = src2[SHW-1:0];

   always_comb begin
      add_w   = {1'b0, src1} + {1'b0, src2};
      sub_w   = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_o   = 1'b0;
      alu_ill = 1'b0;
      case (ALU_control)
         OP_AND:  alu_res = src1 & src2;
         OP_OR:   alu_res = src1 | src2;
         OP_XOR:  alu_res = src1 ^ src2;
         OP_NOR:  alu_res = ~(src1 | src2);
         OP_ADD: begin
            alu_res = add_w[WIDTH-1:0];
            alu_c   = add_w[WIDTH];
            alu_o   = (src1[WIDTH-1] == src2[WIDTH-1]) && (add_w[WIDTH-1] != src1[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sub_w[WIDTH-1:0];
            alu_c   = sub_w[WIDTH];
            alu_o   = (src1[WIDTH-1] != src2[WIDTH-1]) && (sub_w[WIDTH-1] != src1[WIDTH-1]);
         end
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
         OP_SLL:  alu_res = src1 << shamt;
         OP_SRL:  alu_res = src1 >> shamt;
         OP_SRA:  alu_res = $signed(src1) >>> shamt;
         default: alu_ill = 1'b1;
      endcase
   end

   assign out_xfer = out_valid_q && out_ready;
   assign reg_free = !out_valid_q || out_ready;
   assign in_xfer  = in_valid && in_ready;

`ifdef ALU_MUL_EN
   localparam logic [3:0]   OP_MUL   = 4'b1001;
   localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);
   localparam logic [SHW:0] CNT_SAT  = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

   typedef enum logic {IDLE, BUSY} state_t;
   state_t           state_q, state_d;
   logic [SHW:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, step_acc, mul_res;
   logic [TAG_W-1:0] mtag_q, mtag_d;
   logic             mul_load;

   assign is_mul   = (ALU_control == OP_MUL);
   assign in_ready = (state_q == IDLE) && reg_free;
   assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

   // cnt_q == CNT_SAT marks a finished product parked in acc_q awaiting a free output register.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      mtag_d   = mtag_q;
      mul_load = 1'b0;
      mul_res  = acc_q;
      case (state_q)
         IDLE: begin
            if (in_xfer && is_mul) begin
               state_d  = BUSY;
               cnt_d    = '0;
               acc_d    = '0;
               mcand_d  = src1;
               mplier_d = src2;
               mtag_d   = in_tag;
            end
         end
         BUSY: begin
            if (cnt_q == CNT_SAT) begin
               if (reg_free) begin
                  mul_load = 1'b1;
                  state_d  = IDLE;
               end
            end else begin
               acc_d    = step_acc;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               if (cnt_q == CNT_LAST) begin
                  if (reg_free) begin
                     mul_load = 1'b1;
                     mul_res  = step_acc;
                     state_d  = IDLE;
                  end else begin
                     cnt_d = CNT_SAT;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         mtag_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         mtag_q   <= mtag_d;
      end
   end
`else
   assign is_mul   = 1'b0;
   assign in_ready = reg_free;
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      res_d       = res_q;
      zero_d      = zero_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      ill_d       = ill_q;
      tag_d       = tag_q;
      if (out_xfer) out_valid_d = 1'b0;
      if (in_xfer && !is_mul) begin
         out_valid_d = 1'b1;
         res_d       = alu_res;
         zero_d      = !alu_ill && (alu_res == '0);
         cout_d      = alu_c;
         ovf_d       = alu_o;
         ill_d       = alu_ill;
         tag_d       = in_tag;
      end
`ifdef ALU_MUL_EN
      if (mul_load) begin
         out_valid_d = 1'b1;
         res_d       = mul_res;
         zero_d      = (mul_res == '0);
         cout_d      = 1'b0;
         ovf_d       = 1'b0;
         ill_d       = 1'b0;
         tag_d       = mtag_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         res_q       <= '0;
         zero_q      <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         ill_q       <= 1'b0;
         tag_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         zero_q      <= zero_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         ill_q       <= ill_d;
         tag_q       <= tag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = res_q;
   assign zero      = zero_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;
   assign illegal   = ill_q;
   assign out_tag   = tag_q;

endmodule
